// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes, shift-add multiply and persistent carry
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opcode,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] M,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);
  localparam logic [5:0] OP_ADD = 6'd1, OP_SUB = 6'd2, OP_AND = 6'd3, OP_OR = 6'd4, OP_XOR = 6'd5;
  localparam logic [5:0] OP_NOTD = 6'd6, OP_INCD = 6'd7, OP_DECD = 6'd8, OP_NOTM = 6'd9, OP_INCM = 6'd10, OP_DECM = 6'd11;
  localparam logic [5:0] OP_ASLD = 6'd12, OP_ASRD = 6'd13, OP_ASLM = 6'd14, OP_ASRM = 6'd15;
  localparam logic [5:0] OP_NEG1 = 6'd16, OP_ONE = 6'd17, OP_NEGD = 6'd18, OP_NEGM = 6'd19;
  localparam logic [5:0] OP_MUL = 6'd20, OP_SHL = 6'd21, OP_SAR = 6'd22, OP_ADC = 6'd23, OP_SBB = 6'd24;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [WIDTH-1:0] r, acc_nx;
  logic [3:0] flags_q, flags_d;
  logic [SHW-1:0] cnt_q, cnt_d, s;
  logic [WIDTH:0] sum, dif, shl, sar;
  logic accept, cin, c, v;
  // The carry register always equals the C flag of the last completed op
  always_comb begin
    s = M[SHW-1:0];
    cin = (opcode == OP_ADC || opcode == OP_SBB) && flags_q[3];
    sum = {1'b0, D} + {1'b0, M} + {{WIDTH{1'b0}}, cin};
    dif = {1'b0, D} - {1'b0, M} - {{WIDTH{1'b0}}, cin};
    shl = {1'b0, D} << s;
    sar = $signed({D, 1'b0}) >>> s;
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (opcode)
      OP_ADD, OP_ADC: begin
        r = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = (D[WIDTH-1] == M[WIDTH-1]) && (sum[WIDTH-1] != D[WIDTH-1]);
      end
      OP_SUB, OP_SBB: begin
        r = dif[WIDTH-1:0];
        c = dif[WIDTH];
        v = (D[WIDTH-1] != M[WIDTH-1]) && (dif[WIDTH-1] != D[WIDTH-1]);
      end
      OP_AND:  r = D & M;
      OP_OR:   r = D | M;
      OP_XOR:  r = D ^ M;
      OP_NOTD: r = ~D;
      OP_INCD: r = D + ONE;
      OP_DECD: r = D - ONE;
      OP_NOTM: r = ~M;
      OP_INCM: r = M + ONE;
      OP_DECM: r = M - ONE;
      OP_ASLD: begin r = {D[WIDTH-2:0], 1'b0}; c = D[WIDTH-1]; end
      OP_ASRD: begin r = {D[WIDTH-1], D[WIDTH-1:1]}; c = D[0]; end
      OP_ASLM: begin r = {M[WIDTH-2:0], 1'b0}; c = M[WIDTH-1]; end
      OP_ASRM: begin r = {M[WIDTH-1], M[WIDTH-1:1]}; c = M[0]; end
      OP_NEG1: r = '1;
      OP_ONE:  r = ONE;
      OP_NEGD: r = -D;
      OP_NEGM: r = -M;
      OP_SHL:  begin r = shl[WIDTH-1:0]; c = shl[WIDTH]; end
      OP_SAR:  begin r = sar[WIDTH:1]; c = sar[0]; end
      default: ;
    endcase
  end
  always_comb begin
    state_d = state_q;
    result_d = result_q;
    flags_d = flags_q;
    acc_d = acc_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    cnt_d = cnt_q;
    in_ready = state_q == IDLE || (state_q == DONE && out_ready);
    accept = in_valid && in_ready;
    acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);
    if (state_q == BUSY) begin
      acc_d = acc_nx;
      mcand_d = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d = cnt_q + SHW'(1);
      if (cnt_q == SHW'(WIDTH - 1)) begin
        state_d = DONE;
        result_d = acc_nx;
        flags_d = {1'b0, acc_nx[WIDTH-1], acc_nx == '0, 1'b0};
      end
    end else if (accept) begin
      if (opcode == OP_MUL) begin
        state_d = BUSY;
        acc_d = '0;
        mcand_d = D;
        mplier_d = M;
        cnt_d = '0;
      end else begin
        state_d = DONE;
        result_d = r;
        flags_d = {c, r[WIDTH-1], r == '0, v};
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      result_q <= '0;
      flags_q <= '0;
      acc_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      result_q <= result_d;
      flags_q <= flags_d;
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q <= cnt_d;
    end
  end
  assign out_valid = state_q == DONE;
  assign busy = state_q == BUSY;
  assign result = result_q;
  assign flags = flags_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq at WIDTH=16
module tb_alu_seq;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [5:0] opcode;
  logic [W-1:0] D, M, result;
  logic [3:0] flags;
  logic [W+3:0] exp_q[$];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .D(D), .M(M), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flags(flags), .busy(busy)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [W-1:0] d, input logic [W-1:0] m, input logic [W+3:0] exp);
    int t = 0;
    opcode = op;
    D = d;
    M = m;
    in_valid = 1'b1;
    exp_q.push_back(exp);
    while (!in_ready && t < 100) begin
      step();
      t++;
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    opcode = '0;
    D = '0;
    M = '0;
    repeat (3) step();
    n_chk++;
    if (result !== '0 || flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_data: result %h flags %b, want 0000 0000", result, flags);
    end
    n_chk++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ctrl: out_valid %b busy %b in_ready %b, want 0 0 1", out_valid, busy, in_ready);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_ops();
    logic [5:0] ops[16];
    logic [W-1:0] ds[16], ms[16], rs[16];
    logic [3:0] fs[16];
    logic [W+3:0] exp;
    int lat;
    ops = '{6'h01, 6'h02, 6'h3F, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h0B, 6'h0C, 6'h0F, 6'h10, 6'h11, 6'h12, 6'h00, 6'h02};
    ds  = '{16'h7FFF, 16'h0001, 16'h1234, 16'hF0F0, 16'h00F0, 16'hA5A5, 16'hFFFF, 16'h7FFF,
            16'h0000, 16'hC001, 16'h0000, 16'h1234, 16'h0000, 16'h0005, 16'hFFFF, 16'h8000};
    ms  = '{16'h0001, 16'h0002, 16'h5678, 16'hFF00, 16'h0F00, 16'hA5A5, 16'h0000, 16'h0000,
            16'h0000, 16'h0000, 16'h8003, 16'h1234, 16'h0000, 16'h0000, 16'hFFFF, 16'h0001};
    rs  = '{16'h8000, 16'hFFFF, 16'h0000, 16'hF000, 16'h0FF0, 16'h0000, 16'h0000, 16'h8000,
            16'hFFFF, 16'h8002, 16'hC001, 16'hFFFF, 16'h0001, 16'hFFFB, 16'h0000, 16'h7FFF};
    fs  = '{4'b0101, 4'b1100, 4'b0010, 4'b0100, 4'b0000, 4'b0010, 4'b0010, 4'b0100,
            4'b0100, 4'b1100, 4'b1100, 4'b0100, 4'b0000, 4'b0100, 4'b0010, 4'b0001};
    for (int i = 0; i < 16; i++) begin
      issue(ops[i], ds[i], ms[i], {rs[i], fs[i]});
      wait_out(lat);
      exp = exp_q.pop_front();
      n_chk++;
      if (lat !== 0 || out_valid !== 1'b1 || {result, flags} !== exp) begin
        n_fail++;
        $display("FAIL op%0d(%h): got %h/%b extra_lat %0d, want %h/%b extra_lat 0",
                 i, ops[i], result, flags, lat, exp[W+3:4], exp[3:0]);
      end
    end
  endtask

  task automatic test_shift();
    logic [5:0] ops[5];
    logic [W-1:0] ds[5], ms[5], rs[5];
    logic [3:0] fs[5];
    logic [W+3:0] exp;
    int lat;
    ops = '{6'h16, 6'h15, 6'h15, 6'h16, 6'h15};
    ds  = '{16'h8000, 16'h1234, 16'h8001, 16'h0008, 16'h0001};
    ms  = '{16'h0004, 16'h0000, 16'h0001, 16'h0004, 16'h00F3};
    rs  = '{16'hF800, 16'h1234, 16'h0002, 16'h0000, 16'h0008};
    fs  = '{4'b0100, 4'b0000, 4'b1000, 4'b1010, 4'b0000};
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], ds[i], ms[i], {rs[i], fs[i]});
      wait_out(lat);
      exp = exp_q.pop_front();
      n_chk++;
      if (lat !== 0 || {result, flags} !== exp) begin
        n_fail++;
        $display("FAIL shift%0d: got %h/%b extra_lat %0d, want %h/%b", i, result, flags, lat, exp[W+3:4], exp[3:0]);
      end
    end
  endtask

  task automatic test_carry();
    logic [5:0] ops[4];
    logic [W-1:0] ds[4], ms[4], rs[4];
    logic [3:0] fs[4];
    logic [W+3:0] exp;
    int lat;
    ops = '{6'h01, 6'h17, 6'h02, 6'h18};
    ds  = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0005};
    ms  = '{16'h0001, 16'h0000, 16'h0001, 16'h0002};
    rs  = '{16'h0000, 16'h0001, 16'hFFFF, 16'h0002};
    fs  = '{4'b1010, 4'b0000, 4'b1100, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], ds[i], ms[i], {rs[i], fs[i]});
      wait_out(lat);
      exp = exp_q.pop_front();
      n_chk++;
      if ({result, flags} !== exp) begin
        n_fail++;
        $display("FAIL carry%0d: got %h/%b, want %h/%b", i, result, flags, exp[W+3:4], exp[3:0]);
      end
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] ds[3], ms[3], rs[3];
    logic [3:0] fs[3];
    logic [W+3:0] exp;
    int nb;
    ds = '{16'h0003, 16'h0101, 16'h1234};
    ms = '{16'hFFFE, 16'h0101, 16'h0000};
    rs = '{16'hFFFA, 16'h0201, 16'h0000};
    fs = '{4'b0100, 4'b0000, 4'b0010};
    for (int i = 0; i < 3; i++) begin
      issue(6'h14, ds[i], ms[i], {rs[i], fs[i]});
      nb = 0;
      while (busy && nb < 100) begin
        n_chk++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL mul%0d_busy: in_ready %b out_valid %b, want 0 0", i, in_ready, out_valid);
        end
        step();
        nb++;
      end
      exp = exp_q.pop_front();
      n_chk++;
      if (nb !== 16 || out_valid !== 1'b1 || {result, flags} !== exp) begin
        n_fail++;
        $display("FAIL mul%0d: busy %0d cycles valid %b got %h/%b, want 16 cycles valid 1 %h/%b",
                 i, nb, out_valid, result, flags, exp[W+3:4], exp[3:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W+3:0] exp;
    int lat;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    issue(6'h01, 16'h0010, 16'h0020, {16'h0030, 4'b0000});
    wait_out(lat);
    exp = exp_q.pop_front();
    n_chk++;
    if (lat !== 0 || {result, flags} !== exp) begin
      n_fail++;
      $display("FAIL bp_add: got %h/%b extra_lat %0d, want %h/%b", result, flags, lat, exp[W+3:4], exp[3:0]);
    end
    opcode = 6'h05;
    D = 16'hA5A5;
    M = 16'hFFFF;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_chk++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || {result, flags} !== exp) begin
        n_fail++;
        $display("FAIL bp_hold%0d: in_ready %b valid %b got %h/%b, want 0 1 %h/%b",
                 i, in_ready, out_valid, result, flags, exp[W+3:4], exp[3:0]);
      end
    end
    exp_q.push_back({16'h5A5A, 4'b0000});
    out_ready = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: in_ready %b, want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    exp = exp_q.pop_front();
    n_chk++;
    if (out_valid !== 1'b1 || {result, flags} !== exp) begin
      n_fail++;
      $display("FAIL b2b_xor: valid %b got %h/%b, want 1 %h/%b", out_valid, result, flags, exp[W+3:4], exp[3:0]);
    end
  endtask

  task automatic test_mul_reset();
    int bad = 0;
    step();
    step();
    opcode = 6'h14;
    D = 16'h0003;
    M = 16'hFFFE;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (out_valid !== 1'b0 || busy !== 1'b0 || result !== '0 || flags !== 4'b0000) bad++;
      step();
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL mul_reset: %0d cycles with nonzero outputs, want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_shift();
    test_carry();
    test_mul();
    test_back_to_back();
    test_mul_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 16-bit combinational ALU.
- Accepts one operation per valid/ready handshake and returns a registered result plus flags through a second handshake.
- Keeps the existing 6-bit opcode map. Adds a multi-cycle shift-add multiply, barrel shifts by a variable amount, and add/subtract with carry using a persistent carry register.
- Sits between the register-file read stage and writeback; lets the datapath stall on backpressure.

Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥4 and a power of two.
- SHW, $clog2(WIDTH), width of the shift-amount field taken from M[SHW-1:0].

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept an operation this cycle.
- opcode  input  6  operation code.
- D  input  WIDTH  signed operand D.
- M  input  WIDTH  signed operand M.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered result.
- flags  output  4  {C, N, Z, V}, registered.
- busy  output  1  multiply in progress.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; result=0, flags=0, out_valid=0, busy=0, carry register=0. Reset overrides everything, including a multiply in flight (it is discarded, no output).
- States:
  - IDLE: in_ready=1.
  - BUSY: multiply iterating; in_ready=0, busy=1.
  - DONE: out_valid=1; in_ready=out_ready.
- Accept: occurs when in_valid && in_ready. Operands and opcode are captured in that cycle.
- Single-cycle ops go IDLE/DONE→DONE with the result visible the next cycle (latency 1).
- MUL goes →BUSY for exactly WIDTH cycles, then →DONE (latency WIDTH+1).
- DONE with out_ready=1 and no new accept →IDLE. DONE with out_ready=1 and an accept → back-to-back (DONE or BUSY).
- DONE with out_ready=0: result, flags and out_valid are held stable; no accept.
- Opcodes 000001–010011 keep existing meanings, generalised to WIDTH:
  - ADD, SUB, AND, OR, XOR.
  - NOT D, D+1, D-1, NOT M, M+1, M-1.
  - ASL D, ASR D, ASL M, ASR M (shift by 1).
  - constant -1, constant 1, negate D, negate M.
- New opcodes:
  - 010100 MUL: low WIDTH bits of D*M, computed by unsigned shift-add, one partial product per cycle.
  - 010101 SHL: D << M[SHW-1:0].
  - 010110 SAR: D >>> M[SHW-1:0], sign-filled.
  - 010111 ADC: D+M+Cst.
  - 011000 SBB: D-M-Cst, where Cst is the carry register.
- Any other opcode: result=0, completes in 1 cycle.
- Flags are computed on every completed op.
  - N=result[WIDTH-1] for all ops.
  - Z=(result==0) for all ops.
  - C:
    - ADD/ADC: unsigned carry-out.
    - SUB/SBB: borrow (1 when D < M+borrow-in, unsigned).
    - ASL/SHL: last bit shifted out of the MSB.
    - ASR/SAR: last bit shifted out of the LSB.
    - Shift amount 0: C=0.
    - All other ops: C=0.
  - V:
    - ADD/ADC: operands have equal sign and the result sign differs.
    - SUB/SBB: operands have differing signs and the result sign differs from D.
    - All other ops: V=0.
- Carry register is loaded with the C flag of every completed op at the DONE entry edge; it is read at accept time.
- Arithmetic wraps modulo 2^WIDTH; no saturation.

Test Plan:
- WIDTH=16, ADD D=0x7FFF M=0x0001 -> result=0x8000, flags=4'b0101, latency 1.
- SUB D=0x0001 M=0x0002 -> result=0xFFFF, flags=4'b1100. Illegal opcode 111111 -> result=0x0000, flags=4'b0010.
- MUL D=0x0003 M=0xFFFE -> busy=1 for 16 cycles, out_valid on cycle 17, result=0xFFFA, flags=4'b0100. Assert rst_n=0 in cycle 8 of a repeat -> out_valid never rises, all outputs 0.
- ADD 0xFFFF+0x0001 -> result=0x0000, flags=4'b1010; then ADC 0x0000+0x0000 -> result=0x0001, flags=4'b0000.
- SAR D=0x8000 M=4 -> result=0xF800, C=0. SHL D=0x1234 M=0 -> result=0x1234, C=0. SHL D=0x8001 M=1 -> result=0x0002, C=1.
- Backpressure: hold out_ready=0 for 5 cycles after an ADD completes -> result/flags stable, in_ready=0. Raise out_ready together with in_valid (XOR) -> XOR result valid the next cycle, no bubble.
